// File: rtl/miner_job_if.sv
// Host byte streams plus miner job/result bus seen by miner_job_controller.
interface miner_job_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] midstate;
    logic [95:0]  work_data;
    logic [31:0]  nonce_min;
    logic [31:0]  nonce_max;
    logic         miner_reset;
    logic [31:0]  golden_nonce;
    logic         new_golden_nonce;
    logic         busy;

    modport master (
        input  in_data, in_valid, out_ready, golden_nonce, new_golden_nonce,
        output in_ready, out_data, out_valid, midstate, work_data,
               nonce_min, nonce_max, miner_reset, busy
    );

    modport slave (
        output in_data, in_valid, out_ready, golden_nonce, new_golden_nonce,
        input  in_ready, out_data, out_valid, midstate, work_data,
               nonce_min, nonce_max, miner_reset, busy
    );
endinterface

// File: rtl/miner_job_controller.sv
// Loads 52-byte job frames into the SHA-256d miner, then reports a golden nonce or range exhaustion
// as a 5-byte result frame. Optional job abort from RUN enabled by defining MINER_JOB_ABORT_EN.
module miner_job_controller #(
    parameter int unsigned LOOP_LOG2        = 5,
    parameter int unsigned DRAIN_CYCLES     = 256,
    parameter int unsigned MINER_RST_CYCLES = 2
) (
    input  logic         hash_clk,
    input  logic         reset_n,
    miner_job_if.master  job_if
);

    localparam int unsigned FRAME_BYTES = 52;
    localparam int unsigned SHADOW_W    = FRAME_BYTES * 8;
    localparam int unsigned CNT_W       = 6;
    localparam int unsigned RUN_W       = 39;
    localparam int unsigned RST_W       = (MINER_RST_CYCLES > 1) ? $clog2(MINER_RST_CYCLES) : 1;
`ifdef MINER_JOB_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_LOAD, S_START, S_RUN, S_SEND} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic [255:0]        midstate_q, midstate_d;
    logic [95:0]         work_q, work_d;
    logic [31:0]         nmin_q, nmin_d;
    logic [31:0]         nmax_q, nmax_d;
    logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic [31:0]         res_q, res_d;
    logic [2:0]          snd_cnt_q, snd_cnt_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                miner_reset_q, miner_reset_d;
    logic                busy_q, busy_d;

    logic                byte_in_c;
    logic                byte_out_c;
    logic                abort_c;
    logic [8:0]          wr_pos_c;
    logic [32:0]         range_c;
    logic [RUN_W-1:0]    limit_c;

    assign byte_in_c  = job_if.in_valid && in_ready_q;
    assign byte_out_c = out_valid_q && job_if.out_ready;
    assign abort_c    = ABORT_EN && byte_in_c && (state_q == S_RUN);
    assign wr_pos_c   = {6'(FRAME_BYTES - 1) - cnt_q, 3'b000};

    // 33-bit range so a full 0..FFFFFFFF sweep counts 2^32 nonces; inverted bounds mean empty range
    assign range_c = (nmax_q >= nmin_q) ? ({1'b0, nmax_q} - {1'b0, nmin_q} + 33'd1) : 33'd0;
    assign limit_c = (RUN_W'(range_c) << LOOP_LOG2) + RUN_W'(DRAIN_CYCLES);

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_LOAD;
            cnt_q         <= '0;
            shadow_q      <= '0;
            midstate_q    <= '0;
            work_q        <= '0;
            nmin_q        <= '0;
            nmax_q        <= '0;
            rst_cnt_q     <= '0;
            run_cnt_q     <= '0;
            res_q         <= '0;
            snd_cnt_q     <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            miner_reset_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            midstate_q    <= midstate_d;
            work_q        <= work_d;
            nmin_q        <= nmin_d;
            nmax_q        <= nmax_d;
            rst_cnt_q     <= rst_cnt_d;
            run_cnt_q     <= run_cnt_d;
            res_q         <= res_d;
            snd_cnt_q     <= snd_cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            miner_reset_q <= miner_reset_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        midstate_d  = midstate_q;
        work_d      = work_q;
        nmin_d      = nmin_q;
        nmax_d      = nmax_q;
        rst_cnt_d   = rst_cnt_q;
        run_cnt_d   = run_cnt_q;
        res_d       = res_q;
        snd_cnt_d   = snd_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_LOAD: begin
                if (byte_in_c) begin
                    shadow_d[wr_pos_c +: 8] = job_if.in_data;
                    if (cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
                        midstate_d = shadow_d[415:160];
                        work_d     = shadow_d[159:64];
                        nmin_d     = shadow_d[63:32];
                        nmax_d     = shadow_d[31:0];
                        cnt_d      = '0;
                        rst_cnt_d  = '0;
                        state_d    = S_START;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_START: begin
                run_cnt_d = '0;
                if (rst_cnt_q == RST_W'(MINER_RST_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
                // An abort byte starts the next frame and swallows any same-cycle find
                if (abort_c) begin
                    shadow_d[SHADOW_W-1 -: 8] = job_if.in_data;
                    cnt_d   = CNT_W'(1);
                    state_d = S_LOAD;
                end else if (job_if.new_golden_nonce) begin
                    res_d       = job_if.golden_nonce;
                    out_data_d  = 8'h01;
                    out_valid_d = 1'b1;
                    snd_cnt_d   = '0;
                    state_d     = S_SEND;
                end else if (run_cnt_q == limit_c) begin
                    res_d       = '0;
                    out_data_d  = 8'h00;
                    out_valid_d = 1'b1;
                    snd_cnt_d   = '0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (byte_out_c) begin
                    if (snd_cnt_q == 3'd4) begin
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        cnt_d       = '0;
                        state_d     = S_LOAD;
                    end else begin
                        out_data_d = res_q[31:24];
                        res_d      = {res_q[23:0], 8'h00};
                        snd_cnt_d  = snd_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase

        in_ready_d    = (state_d == S_LOAD) || (ABORT_EN && (state_d == S_RUN));
        miner_reset_d = (state_d == S_START);
        busy_d        = (state_d != S_LOAD);
    end

    assign job_if.in_ready    = in_ready_q;
    assign job_if.out_data    = out_data_q;
    assign job_if.out_valid   = out_valid_q;
    assign job_if.midstate    = midstate_q;
    assign job_if.work_data   = work_q;
    assign job_if.nonce_min   = nmin_q;
    assign job_if.nonce_max   = nmax_q;
    assign job_if.miner_reset = miner_reset_q;
    assign job_if.busy        = busy_q;

endmodule

// File: tb/tb_miner_job_controller.sv
// Randomised scoreboard bench for miner_job_controller: expected result bytes are queued at stimulus
// time from a range/latency reference model and popped by an independent output monitor.
module tb_miner_job_controller;

    localparam int unsigned LOOP_LOG2 = 5;
    localparam int unsigned DRAIN     = 256;
`ifdef MINER_JOB_ABORT_EN
    localparam bit ABORT_EXP = 1'b1;
`else
    localparam bit ABORT_EXP = 1'b0;
`endif

    logic hash_clk = 1'b0;
    logic reset_n  = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   hold_until = 0;

    logic [7:0]   exp_q[$];
    logic [415:0] fbits;
    logic         prev_v   = 1'b0;
    logic         prev_acc = 1'b0;
    logic [7:0]   prev_d   = 8'h00;

    miner_job_if bus();

    miner_job_controller #(
        .LOOP_LOG2        (LOOP_LOG2),
        .DRAIN_CYCLES     (DRAIN),
        .MINER_RST_CYCLES (2)
    ) dut (
        .hash_clk (hash_clk),
        .reset_n  (reset_n),
        .job_if   (bus)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: cycles from RUN entry until exhaustion is declared
    function automatic longint ref_limit(input logic [31:0] nmin, input logic [31:0] nmax);
        longint rng;
        rng = (nmax >= nmin) ? (longint'(nmax) - longint'(nmin) + 1) : 0;
        return rng * (longint'(1) << LOOP_LOG2) + longint'(DRAIN);
    endfunction

    // Output monitor: random back-pressure, hold-stability and scoreboard compare
    always @(negedge hash_clk) begin
        cyc++;
        if (prev_v && !prev_acc) begin
            check("hold_valid", 256'(bus.out_valid), 256'(1));
            check("hold_data", 256'(bus.out_data), 256'(prev_d));
        end
        if (cyc < hold_until) bus.out_ready = 1'b0;
        else                  bus.out_ready = ($urandom_range(0, 3) != 0);
        prev_v   = bus.out_valid;
        prev_d   = bus.out_data;
        prev_acc = bus.out_valid && bus.out_ready;
        if (prev_acc) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte actual=%0h expected=none", bus.out_data);
            end else begin
                check("out_byte", 256'(bus.out_data), 256'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge hash_clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && t < 200) begin
            @(negedge hash_clk);
            t++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
        end
        @(posedge hash_clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [255:0] ms, input logic [95:0] wd,
                           input logic [31:0] nmin, input logic [31:0] nmax,
                           input int find_at, input logic [31:0] gold,
                           input bit stall, input int first);
        longint limit;
        bit     found;
        int     exp_lat;
        int     rc;
        int     cnt;
        int     t;
        logic [39:0] res;
        fbits   = {ms, wd, nmin, nmax};
        limit   = ref_limit(nmin, nmax);
        found   = (find_at >= 0) && (longint'(find_at) <= limit);
        exp_lat = found ? find_at + 1 : int'(limit) + 1;
        res     = found ? {8'h01, gold} : 40'h0;
        for (int k = 4; k >= 0; k--) exp_q.push_back(res[k*8 +: 8]);
        if (stall) hold_until = 32'h7fff_ffff;
        for (int i = first; i < 52; i++) send_byte(fbits[415 - 8*i -: 8]);

        @(negedge hash_clk);
        check("midstate", bus.midstate, ms);
        check("work_data", 256'(bus.work_data), 256'(wd));
        check("nonce_min", 256'(bus.nonce_min), 256'(nmin));
        check("nonce_max", 256'(bus.nonce_max), 256'(nmax));
        rc = 0;
        while (bus.miner_reset && rc < 20) begin
            rc++;
            @(negedge hash_clk);
        end
        check("miner_reset_cycles", 256'(rc), 256'(2));
        check("busy_run", 256'(bus.busy), 256'(1));
        check("in_ready_run", 256'(bus.in_ready), 256'(ABORT_EXP));

        cnt = 0;
        while (!bus.out_valid && cnt < 70000) begin
            if (cnt == find_at) begin
                bus.golden_nonce     = gold;
                bus.new_golden_nonce = 1'b1;
            end
            @(negedge hash_clk);
            cnt++;
        end
        check("result_latency", 256'(cnt), 256'(exp_lat));
        if (stall) begin
            repeat (20) @(negedge hash_clk);
            hold_until = 0;
        end
        t = 0;
        while (bus.busy && t < 500) begin
            @(negedge hash_clk);
            t++;
        end
        check("busy_done", 256'(bus.busy), 256'(0));
        check("frame_complete", 256'(exp_q.size()), 256'(0));
        // A level-high find lingering into LOAD must not produce anything
        repeat (5) @(negedge hash_clk);
        bus.new_golden_nonce = 1'b0;
    endtask

`ifdef MINER_JOB_ABORT_EN
    task automatic abort_test();
        logic [255:0] ms_b;
        int t = 0;
        fbits = {256'h0, 96'h0, 32'h0, 32'hFFFF_FFFF};
        for (int i = 0; i < 52; i++) send_byte(fbits[415 - 8*i -: 8]);
        while ((bus.miner_reset || !bus.busy) && t < 50) begin
            @(negedge hash_clk);
            t++;
        end
        repeat (10) @(negedge hash_clk);
        ms_b = {8{32'hA5A5_0F0F}};
        bus.in_valid         = 1'b1;
        bus.in_data          = ms_b[255:248];
        bus.golden_nonce     = 32'hDEAD_BEEF;
        bus.new_golden_nonce = 1'b1;
        @(posedge hash_clk);
        #1;
        bus.in_valid         = 1'b0;
        bus.new_golden_nonce = 1'b0;
        @(negedge hash_clk);
        check("abort_to_load", 256'(bus.busy), 256'(0));
        run_job(ms_b, 96'h1111_2222_3333, 32'd7, 32'd7, -1, 32'h0, 1'b0, 1);
    endtask
`endif

    initial begin
        #20_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] ms;
        logic [95:0]  wd;
        logic [31:0]  nmin, nmax, gold;
        int           fa;
        longint       lim;

        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b0;
        bus.golden_nonce = 32'h0;
        bus.new_golden_nonce = 1'b0;

        repeat (3) @(negedge hash_clk);
        check("rst_in_ready", 256'(bus.in_ready), 256'(1));
        check("rst_out_valid", 256'(bus.out_valid), 256'(0));
        check("rst_busy", 256'(bus.busy), 256'(0));
        check("rst_miner_reset", 256'(bus.miner_reset), 256'(0));
        check("rst_nonce_max", 256'(bus.nonce_max), 256'(0));
        reset_n = 1'b1;

        // Frame 0x00..0x33, golden nonce 100 cycles into RUN
        for (int i = 0; i < 32; i++) ms[255 - 8*i -: 8] = 8'(i);
        for (int i = 0; i < 12; i++) wd[95 - 8*i -: 8] = 8'(32 + i);
        run_job(ms, wd, 32'h2C2D_2E2F, 32'h3031_3233, 100, 32'h1234_ABCD, 1'b0, 0);

        // Exhaustion over four nonces, empty range, and a find on the exhaustion cycle
        run_job(ms, wd, 32'h10, 32'h13, -1, 32'h0, 1'b0, 0);
        run_job(ms, wd, 32'd9, 32'd5, -1, 32'h0, 1'b0, 0);
        run_job(ms, wd, 32'd9, 32'd5, 256, 32'hCAFE_0001, 1'b0, 0);

        // Sink stalled while the result frame is pending
        run_job(ms, wd, 32'd0, 32'd1, 10, 32'h0BAD_F00D, 1'b1, 0);

        // Reset part-way through a frame, then a complete frame must load cleanly
        fbits = {ms, wd, 32'h1, 32'h2};
        for (int i = 0; i < 20; i++) send_byte(fbits[415 - 8*i -: 8]);
        @(negedge hash_clk);
        reset_n = 1'b0;
        #2;
        check("midrst_midstate", bus.midstate, 256'h0);
        check("midrst_in_ready", 256'(bus.in_ready), 256'(1));
        check("midrst_miner_reset", 256'(bus.miner_reset), 256'(0));
        @(negedge hash_clk);
        reset_n = 1'b1;
        run_job(~ms, ~wd, 32'h40, 32'h41, -1, 32'h0, 1'b0, 0);

`ifdef MINER_JOB_ABORT_EN
        abort_test();
`endif

        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 8; k++) ms = {ms[223:0], 32'($urandom)};
            for (int k = 0; k < 3; k++) wd = {wd[63:0], 32'($urandom)};
            nmin = 32'($urandom);
            if ($urandom_range(0, 3) == 0) nmax = nmin - 32'($urandom_range(1, 100));
            else                           nmax = nmin + 32'($urandom_range(0, 6));
            lim  = ref_limit(nmin, nmax);
            fa   = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, int'(lim) + 40));
            gold = 32'($urandom);
            run_job(ms, wd, nmin, nmax, fa, gold, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/miner_job_controller.md
Name: miner_job_controller

Overview:
- Host-side companion to the SHA-256d miner core.
- Receives a 52-byte job frame on a byte stream and drives the miner's job inputs and reset. It then watches for a golden nonce or range exhaustion and returns a 5-byte result frame on an outbound byte stream.
- Sits between the host link (UART/FIFO bridge) and the miner core. It is the producer of the miner's job interface and the consumer of its result interface.

Parameters:
- LOOP_LOG2, 5, must match the miner core; one nonce is tried every 2^LOOP_LOG2 cycles.
- DRAIN_CYCLES, 256, extra RUN cycles after the nominal range end before "exhausted" is declared (covers pipeline latency).
- MINER_RST_CYCLES, 2, number of cycles miner_reset is held high at job start (minimum 1).

Ports:
- hash_clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- in_data  in  8  job byte
- in_valid  in  1  job byte valid
- in_ready  out  1  controller accepts in_data this cycle
- out_data  out  8  result byte
- out_valid  out  1  result byte valid
- out_ready  in  1  sink accepts out_data this cycle
- midstate  out  256  to miner
- work_data  out  96  to miner
- nonce_min  out  32  to miner
- nonce_max  out  32  to miner
- miner_reset  out  1  active-high reset pulse to miner
- golden_nonce  in  32  from miner
- new_golden_nonce  in  1  from miner; level, may stay high after a find
- busy  out  1  high in START/RUN/SEND

Behaviour:
- Clock and reset:
  - Single clock hash_clk. reset_n is asynchronous active-low.
  - Reset values: all outputs 0, except in_ready = 1. State = LOAD, byte counter = 0.
- Handshakes:
  - A byte transfers when valid && ready on a rising edge.
  - out_data and out_valid hold stable until accepted.
- Job frame (52 bytes, MSB first within each field):
  - bytes 0-31 midstate[255:0]
  - bytes 32-43 work_data[95:0]
  - bytes 44-47 nonce_min
  - bytes 48-51 nonce_max
  - Bytes go into a shadow register, not the live outputs.
- States:
  - LOAD: in_ready = 1. Each accepted byte increments the counter (0..51). On byte 51, copy shadow to the live outputs and go to START.
  - START: in_ready = 0. miner_reset = 1 for MINER_RST_CYCLES cycles, with the live outputs already stable. Clear run counter and found flag, then go to RUN.
  - RUN: in_ready = 0. Run counter (39 bits) increments every cycle.
  - RUN, found: on the first cycle new_golden_nonce = 1, latch golden_nonce and status 0x01, go to SEND.
  - RUN, exhausted: when run counter == ((nonce_max - nonce_min + 1) << LOOP_LOG2) + DRAIN_CYCLES, status 0x00 with nonce 0, go to SEND.
  - SEND: emit status, then nonce[31:24], [23:16], [15:8], [7:0]. After the 5th byte is accepted, go to LOAD with counter = 0.
- Range arithmetic:
  - Computed in 33 bits, so min 0 / max FFFFFFFF gives 2^32.
  - If nonce_max < nonce_min, the range is 0 and exhaustion occurs after DRAIN_CYCLES.
- Simultaneous found and exhaustion in the same cycle: found wins (status 0x01).
- new_golden_nonce high during LOAD, START or SEND is ignored. The value is sampled only in RUN, and only while miner_reset = 0.
- Live outputs hold their values from START through the following LOAD until the next frame completes.
- reset_n asserted mid-frame, mid-run or mid-send:
  - All state is discarded immediately.
  - Partial frames are dropped and no result is emitted.
  - miner_reset returns to 0.

Optional Feature:
- Macro MINER_JOB_ABORT_EN.
- Defined:
  - in_ready = 1 in RUN.
  - An accepted byte in RUN aborts the job: it is stored as byte 0, the counter becomes 1, the state goes to LOAD, and no result frame is sent.
  - A golden nonce arriving in the abort cycle is discarded.
- Undefined: in_ready = 0 in RUN and in_valid is ignored there.

Test Plan:
- Reset release, then 52 bytes 0x00..0x33 streamed -> midstate = 0x00..1F (MSB first), work_data = 0x20..2B, nonce_min = 0x2C2D2E2F, nonce_max = 0x30313233. miner_reset is high exactly 2 cycles after byte 51.
- Job sent, model asserts new_golden_nonce with golden_nonce = 0x1234ABCD after 100 RUN cycles and holds it high -> out bytes 01 12 34 AB CD, single frame, busy drops after the last accept.
- LOOP_LOG2 = 5, nonce_min = 0x10, nonce_max = 0x13, DRAIN_CYCLES = 256, no find -> result 00 00 00 00 00 exactly 128 + 256 RUN cycles after RUN entry.
- nonce_max = 5 < nonce_min = 9 -> exhausted frame after 256 RUN cycles. Additionally, found and exhaust in the same cycle -> status 01.
- out_ready held low 20 cycles during SEND -> out_data/out_valid stable, no byte lost. reset_n pulsed mid-frame at byte 20 -> next full 52-byte frame loads correctly.
- MINER_JOB_ABORT_EN defined, a byte sent during RUN -> no result frame, 51 further bytes start a new job. Undefined -> in_ready stays 0 in RUN.
